// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Converts the multiplier product into a sign flag and DIGITS decimal digits
// for the display path. The last result is held until a new one is latched.

// Per-digit correction: any digit >= 5 gets +3, so the next left shift
// carries into the following digit.
module product_bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin_In,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Neg_Out,
  output logic [4*DIGITS-1:0]   BCD_Out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAG_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [WIDTH-1:0]         mag;
  logic                     sign_r;
  logic [DIGITS-1:0][3:0]   bcd_work;
  logic [DIGITS-1:0][3:0]   bcd_adj;
  logic [4*DIGITS-1:0]      bcd_next;
  logic [WIDTH-1:0]         mag_next;
  logic                     in_sign;
  logic [WIDTH-1:0]         in_mag;

  // Sign/magnitude split of the incoming value. 16'h8000 negates to 32768,
  // which still fits the unsigned magnitude register.
  assign in_sign = SIGNED ? Bin_In[WIDTH-1] : 1'b0;
  assign in_mag  = in_sign ? (~Bin_In + MAG_ONE) : Bin_In;

  // One correction cell per digit, all in parallel.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      product_bcd_digit_adj u_adj (
        .din  (bcd_work[gi]),
        .dout (bcd_adj[gi])
      );
    end
  endgenerate

  // Corrected digits and remaining magnitude shift left as one register.
  assign {bcd_next, mag_next} = {bcd_adj, mag} << 1;

  // Control FSM with registered outputs; the result registers only load on
  // the final shift edge so the display never sees partial values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mag      <= '0;
      sign_r   <= 1'b0;
      bcd_work <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Neg_Out  <= 1'b0;
      BCD_Out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            state    <= SHIFT;
            Busy     <= 1'b1;
            sign_r   <= in_sign;
            mag      <= in_mag;
            bcd_work <= '0;
            cnt      <= CNT_INIT;
          end
        end
        SHIFT: begin
          bcd_work <= bcd_next;
          mag      <= mag_next;
          cnt      <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            BCD_Out <= bcd_next;
            Neg_Out <= sign_r;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench: stimulus pushes model results into per-instance queues,
// monitors pop and compare on every Done pulse.
module tb_product_bcd_converter;

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s, start_u;
  logic [15:0] bin_s, bin_u;
  logic        busy_s, done_s, neg_s;
  logic        busy_u, done_u, neg_u;
  logic [19:0] bcd_s, bcd_u;

  int vectors = 0;
  int miscompares = 0;
  exp_t q_s[$];
  exp_t q_u[$];

  always #5 clk = ~clk;

  product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_s (
    .Clk(clk), .Reset(rst), .Start(start_s), .Bin_In(bin_s),
    .Busy(busy_s), .Done(done_s), .Neg_Out(neg_s), .BCD_Out(bcd_s));

  product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_u (
    .Clk(clk), .Reset(rst), .Start(start_u), .Bin_In(bin_u),
    .Busy(busy_u), .Done(done_u), .Neg_Out(neg_u), .BCD_Out(bcd_u));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic, decimal digits by repeated /10.
  function automatic exp_t model(input logic [15:0] v, input bit sgn);
    exp_t r;
    int   val;
    val   = sgn ? int'($signed(v)) : int'(v);
    r.neg = (val < 0);
    if (val < 0) val = -val;
    r.bcd = '0;
    for (int i = 0; i < 5; i++) begin
      r.bcd[4*i +: 4] = 4'(val % 10);
      val = val / 10;
    end
    return r;
  endfunction

  // Monitors: every Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done_s) begin
      if (q_s.size() == 0) chk("unexpected_done_s", 1, 0);
      else begin
        e = q_s.pop_front();
        chk("bcd_s", bcd_s, e.bcd);
        chk("neg_s", neg_s, e.neg);
        for (int i = 0; i < 5; i++) if (bcd_s[4*i +: 4] > 4'd9) chk("digit_range_s", bcd_s[4*i +: 4], 9);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_u) begin
      if (q_u.size() == 0) chk("unexpected_done_u", 1, 0);
      else begin
        e = q_u.pop_front();
        chk("bcd_u", bcd_u, e.bcd);
        chk("neg_u", neg_u, e.neg);
      end
    end
  end

  // Bounded wait for Done on the selected instance, then one idle cycle.
  task automatic wait_done(input bit uns);
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (uns ? done_u : done_s) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) chk(uns ? "timeout_u" : "timeout_s", 0, 1);
    @(negedge clk);
  endtask

  // One conversion; optionally scramble Bin_In right after acceptance.
  task automatic run(input bit uns, input logic [15:0] v, input bit scramble);
    @(negedge clk);
    if (uns) begin start_u = 1; bin_u = v; q_u.push_back(model(v, 1'b0)); end
    else     begin start_s = 1; bin_s = v; q_s.push_back(model(v, 1'b1)); end
    @(negedge clk);
    start_u = 0; start_s = 0;
    if (scramble) begin bin_u = 16'($urandom); bin_s = 16'($urandom); end
    wait_done(uns);
  endtask

  initial begin
    int busy_cnt, done_at, bad, d1, d2;
    logic [15:0] dir_s [6];
    rst = 1; start_s = 0; start_u = 0; bin_s = '0; bin_u = '0;
    #1;
    chk("reset_busy", busy_s, 0);
    chk("reset_done", done_s, 0);
    chk("reset_bcd", bcd_s, 0);
    chk("reset_neg", neg_s, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // Latency and Busy window for input zero.
    @(negedge clk);
    start_s = 1; bin_s = 16'h0000; q_s.push_back(model(16'h0000, 1'b1));
    busy_cnt = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start_s = 0;
      if (busy_s) busy_cnt++;
      if (done_s && done_at == 0) done_at = k;
      if (k == 18) chk("done_one_cycle", done_s, 0);
    end
    chk("done_latency", done_at, 17);
    chk("busy_cycles", busy_cnt, 16);

    // Directed signed values.
    dir_s = '{16'h0FF0, 16'h7FFF, 16'hFFFF, 16'h8000, 16'hFF38, 16'h0001};
    foreach (dir_s[i]) run(1'b0, dir_s[i], 1'b0);
    run(1'b1, 16'hFFFF, 1'b0);
    run(1'b1, 16'h0000, 1'b0);

    // Start during SHIFT is ignored; old result held until the Done edge.
    run(1'b0, 16'h0005, 1'b0);
    @(negedge clk);
    start_s = 1; bin_s = 16'h00FF; q_s.push_back(model(16'h00FF, 1'b1));
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start_s = (k == 5);
      if (k == 5) bin_s = 16'h1234;
      if (bcd_s !== 20'h00005 || done_s) bad++;
    end
    start_s = 0;
    chk("hold_during_shift", bad, 0);
    wait_done(1'b0);
    repeat (25) @(negedge clk);

    // Reset mid-conversion discards the result.
    @(negedge clk);
    start_s = 1; bin_s = 16'h3039; q_s.push_back(model(16'h3039, 1'b1));
    repeat (8) begin @(negedge clk); start_s = 0; end
    rst = 1;
    #1;
    chk("midreset_busy", busy_s, 0);
    chk("midreset_bcd", bcd_s, 0);
    chk("midreset_neg", neg_s, 0);
    q_s.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("midreset_no_done_pending", q_s.size(), 0);
    run(1'b0, 16'h3039, 1'b0);

    // Start held high re-triggers every WIDTH+2 cycles.
    @(negedge clk);
    start_s = 1; bin_s = 16'hD8F1;
    q_s.push_back(model(16'hD8F1, 1'b1)); q_s.push_back(model(16'hD8F1, 1'b1));
    d1 = 0; d2 = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_s) begin
        if (d1 == 0) d1 = k;
        else begin d2 = k; start_s = 0; break; end
      end
    end
    start_s = 0;
    chk("rearm_period", d2 - d1, 18);
    repeat (3) @(negedge clk);

    // Randomized, with Bin_In scrambled after acceptance.
    for (int i = 0; i < 30; i++) begin
      run(1'b0, 16'($urandom), 1'b1);
      run(1'b1, 16'($urandom), 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q_s.size() + q_u.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
